vga_fb_scaler: RTL

//  Pipelined pixel fetch between VGA_Driver640x480 and buffer_ram_dp read port.

---
 rtl/vga_fb_scaler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vga_fb_scaler.sv
// Pixel fetch pipeline between the VGA timing driver and the framebuffer read port.
// Applies integer zoom and placement offset, then palette-expands pixels to RGB444.
module vga_fb_scaler #(
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120,
    parameter int unsigned AW     = 15,
    parameter int unsigned DW     = 3,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned SCR_W  = 640,
    parameter int unsigned SCR_H  = 480
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [9:0]    i_pos_x,
    input  logic [8:0]    i_pos_y,
    input  logic          i_pos_valid,
    input  logic [1:0]    i_scale,
    input  logic [9:0]    i_off_x,
    input  logic [8:0]    i_off_y,
    input  logic [11:0]   i_border_rgb,
    input  logic          i_pal_we,
    input  logic [DW-1:0] i_pal_addr,
    input  logic [11:0]   i_pal_data,
    output logic [AW-1:0] o_fb_addr,
    input  logic [DW-1:0] i_fb_data,
    output logic [11:0]   o_pix_rgb,
    output logic          o_pix_valid,
    output logic          o_frame_done
);

    localparam int unsigned PAL_N = 2 ** DW;

    // Reset palette: each index bit drives one colour channel at full intensity.
    function automatic logic [11:0] pal_init(input int unsigned idx);
        logic [2:0] b;
        for (int unsigned k = 0; k < 3; k++) begin
            b[k] = (k < DW) ? idx[k] : 1'b0;
        end
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    endfunction

    // Shadow controls, reloaded only at frame boundaries
    logic [1:0]  r_scale;
    logic [9:0]  r_off_x;
    logic [8:0]  r_off_y;
    logic        r_load;

    logic [11:0] r_pal [PAL_N];

    logic        r_a_inside;
    logic        r_a_valid;
    logic        r_a_last;
    logic [11:0] r_a_border;

    logic        r_dl_inside [RD_LAT];
    logic        r_dl_valid  [RD_LAT];
    logic        r_dl_last   [RD_LAT];
    logic [11:0] r_dl_border [RD_LAT];

    logic [1:0]  w_s;
    logic [12:0] w_ext_w;
    logic [11:0] w_ext_h;
    logic [12:0] w_x_end;
    logic [11:0] w_y_end;
    logic        w_inside;
    logic        w_last;
    logic [9:0]  w_dx;
    logic [8:0]  w_dy;
    logic [9:0]  w_fx;
    logic [8:0]  w_fy;
    logic [31:0] w_addr_full;

    assign w_s     = (r_scale == 2'd3) ? 2'd2 : r_scale;
    assign w_ext_w = 13'(FB_W) << w_s;
    assign w_ext_h = 12'(FB_H) << w_s;
    assign w_x_end = {3'b000, r_off_x} + w_ext_w;
    assign w_y_end = {3'b000, r_off_y} + w_ext_h;

    assign w_inside = i_pos_valid
                    && (i_pos_x >= r_off_x) && ({3'b000, i_pos_x} < w_x_end)
                    && (i_pos_y >= r_off_y) && ({3'b000, i_pos_y} < w_y_end);

    assign w_last = i_pos_valid && (32'(i_pos_x) == SCR_W - 1) && (32'(i_pos_y) == SCR_H - 1);

    assign w_dx        = i_pos_x - r_off_x;
    assign w_dy        = i_pos_y - r_off_y;
    assign w_fx        = w_dx >> w_s;
    assign w_fy        = w_dy >> w_s;
    assign w_addr_full = 32'(w_fy) * FB_W + 32'(w_fx);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scale <= 2'd0;
            r_off_x <= 10'd0;
            r_off_y <= 9'd0;
            r_load  <= 1'b1;
        end else begin
            r_load <= 1'b0;
            if (r_load || o_frame_done) begin
                r_scale <= i_scale;
                r_off_x <= i_off_x;
                r_off_y <= i_off_y;
            end
        end
    end

    // Read-before-write falls out of the registered lookup in Stage C.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < PAL_N; i++) begin
                r_pal[i] <= pal_init(i);
            end
        end else if (i_pal_we) begin
            r_pal[i_pal_addr] <= i_pal_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fb_addr  <= '0;
            r_a_inside <= 1'b0;
            r_a_valid  <= 1'b0;
            r_a_last   <= 1'b0;
            r_a_border <= 12'h000;
        end else begin
            o_fb_addr  <= w_inside ? w_addr_full[AW-1:0] : '0;
            r_a_inside <= w_inside;
            r_a_valid  <= i_pos_valid;
            r_a_last   <= w_last;
            r_a_border <= i_border_rgb;
        end
    end

    // Flags ride alongside the RAM read so they line up with fb_data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_dl_inside[i] <= 1'b0;
                r_dl_valid[i]  <= 1'b0;
                r_dl_last[i]   <= 1'b0;
                r_dl_border[i] <= 12'h000;
            end
        end else begin
            r_dl_inside[0] <= r_a_inside;
            r_dl_valid[0]  <= r_a_valid;
            r_dl_last[0]   <= r_a_last;
            r_dl_border[0] <= r_a_border;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_dl_inside[i] <= r_dl_inside[i-1];
                r_dl_valid[i]  <= r_dl_valid[i-1];
                r_dl_last[i]   <= r_dl_last[i-1];
                r_dl_border[i] <= r_dl_border[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pix_rgb    <= 12'h000;
            o_pix_valid  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_pix_valid  <= r_dl_valid[RD_LAT-1];
            o_frame_done <= r_dl_valid[RD_LAT-1] && r_dl_last[RD_LAT-1];
            if (!r_dl_valid[RD_LAT-1]) begin
                o_pix_rgb <= 12'h000;
            end else if (r_dl_inside[RD_LAT-1]) begin
                o_pix_rgb <= r_pal[i_fb_data];
            end else begin
                o_pix_rgb <= r_dl_border[RD_LAT-1];
            end
        end
    end

endmodule
